// File: rtl/key_event_decoder.sv
// key_event_decoder: debounces an active-low push button and classifies each
// gesture as a short, long or double press, one single-cycle flag per gesture.
//
// Handshake: none. Flags are one-cycle, registered, mutually exclusive pulses
// with no back-pressure; the consumer must sample them every cycle.
module key_event_decoder #(
  parameter logic [19:0] CNT_DEB  = 20'd999_999,
  parameter logic [25:0] CNT_LONG = 26'd49_999_999,
  parameter logic [25:0] CNT_DBL  = 26'd14_999_999
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_in,
  output logic key_level,
  output logic short_flag,
  output logic long_flag,
  output logic double_flag
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRESS1 = 2'd1,
    WAIT2  = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [25:0] TMR_MAX = '1;

  logic        sync0;
  logic        sync1;
  logic        pressed_raw;
  logic [19:0] deb_cnt;

  // Current FSM state; kept as a named typed signal so checkers can bind to it.
  state_t      state;
  state_t      state_next;
  logic [25:0] tmr;
  logic [25:0] tmr_next;
  logic        short_next;
  logic        long_next;
  logic        double_next;

  // Two-flop synchronizer; idles at released (1) so reset looks like no press.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync0 <= 1'b1;
      sync1 <= 1'b1;
    end else begin
      sync0 <= key_in;
      sync1 <= sync0;
    end
  end

  assign pressed_raw = ~sync1;

  // Debounce: a new level must be seen CNT_DEB+1 consecutive cycles to be taken.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      key_level <= 1'b0;
      deb_cnt   <= '0;
    end else if (pressed_raw != key_level) begin
      if (deb_cnt == CNT_DEB) begin
        key_level <= ~key_level;
        deb_cnt   <= '0;
      end else begin
        deb_cnt <= deb_cnt + 20'd1;
      end
    end else begin
      deb_cnt <= '0;
    end
  end

  // Event FSM state, timer and registered flags.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state       <= IDLE;
      tmr         <= '0;
      short_flag  <= 1'b0;
      long_flag   <= 1'b0;
      double_flag <= 1'b0;
    end else begin
      state       <= state_next;
      tmr         <= tmr_next;
      short_flag  <= short_next;
      long_flag   <= long_next;
      double_flag <= double_next;
    end
  end

  // Next-state and flag decode; a key_level change always takes priority over
  // a timer expiry landing in the same cycle.
  always_comb begin
    state_next  = state;
    tmr_next    = (tmr == TMR_MAX) ? tmr : tmr + 26'd1;
    short_next  = 1'b0;
    long_next   = 1'b0;
    double_next = 1'b0;
    case (state)
      IDLE: begin
        tmr_next = '0;
        if (key_level) begin
          state_next = PRESS1;
        end
      end
      PRESS1: begin
        if (!key_level) begin
          state_next = WAIT2;
          tmr_next   = '0;
        end else if (tmr == CNT_LONG) begin
          long_next  = 1'b1;
          state_next = HOLD;
          tmr_next   = '0;
        end
      end
      WAIT2: begin
        if (key_level) begin
          double_next = 1'b1;
          state_next  = HOLD;
          tmr_next    = '0;
        end else if (tmr == CNT_DBL) begin
          short_next = 1'b1;
          state_next = IDLE;
          tmr_next   = '0;
        end
      end
      HOLD: begin
        tmr_next = '0;
        if (!key_level) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        tmr_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed bench for key_event_decoder with CNT_DEB=3, CNT_LONG=40, CNT_DBL=20.
// Observation index n means "state after the n-th rising edge since the
// gesture's first input change was driven"; key_in driven at index 0 is
// captured by edge 1.
module tb_key_event_decoder;

  logic sys_clk;
  logic sys_rst;
  logic key_in;
  logic key_level;
  logic short_flag;
  logic long_flag;
  logic double_flag;

  int tests_run;
  int fail_cnt;

  // Gesture recording filled by play()
  int rise1, fall1, rise2;
  int short_idx, long_idx, double_idx;
  int short_cnt, long_cnt, double_cnt;
  int multi_cnt;

  key_event_decoder #(
    .CNT_DEB (20'd3),
    .CNT_LONG(26'd40),
    .CNT_DBL (26'd20)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .key_in     (key_in),
    .key_level  (key_level),
    .short_flag (short_flag),
    .long_flag  (long_flag),
    .double_flag(double_flag)
  );

  // Clock
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Drive key_in low lo1, high hi1, low lo2 cycles, then high, for total cycles,
  // recording level edges and flag pulses by observation index.
  task automatic play(input int lo1, input int hi1, input int lo2, input int total);
    logic prev;
    int   rises;
    rise1 = -1; fall1 = -1; rise2 = -1;
    short_idx = -1; long_idx = -1; double_idx = -1;
    short_cnt = 0; long_cnt = 0; double_cnt = 0; multi_cnt = 0;
    rises = 0;
    prev = key_level;
    for (int n = 0; n < total; n++) begin
      @(negedge sys_clk);
      if (key_level && !prev) begin
        if (rises == 0) rise1 = n;
        else if (rises == 1) rise2 = n;
        rises++;
      end
      if (!key_level && prev && fall1 < 0) fall1 = n;
      prev = key_level;
      if (short_flag) begin short_cnt++; if (short_idx < 0) short_idx = n; end
      if (long_flag) begin long_cnt++; if (long_idx < 0) long_idx = n; end
      if (double_flag) begin double_cnt++; if (double_idx < 0) double_idx = n; end
      if (int'(short_flag) + int'(long_flag) + int'(double_flag) > 1) multi_cnt++;
      if (n < lo1) key_in = 1'b0;
      else if (n < lo1 + hi1) key_in = 1'b1;
      else if (n < lo1 + hi1 + lo2) key_in = 1'b0;
      else key_in = 1'b1;
    end
  endtask

  task automatic test_reset();
    int bad;
    sys_rst = 1'b1;
    key_in  = 1'b1;
    repeat (3) @(negedge sys_clk);
    tests_run++;
    if (key_level !== 1'b0) begin fail_cnt++; $display("FAIL reset_key_level got %b want 0", key_level); end
    tests_run++;
    if (short_flag !== 1'b0) begin fail_cnt++; $display("FAIL reset_short got %b want 0", short_flag); end
    tests_run++;
    if (long_flag !== 1'b0) begin fail_cnt++; $display("FAIL reset_long got %b want 0", long_flag); end
    tests_run++;
    if (double_flag !== 1'b0) begin fail_cnt++; $display("FAIL reset_double got %b want 0", double_flag); end
    sys_rst = 1'b0;
    bad = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge sys_clk);
      if ({key_level, short_flag, long_flag, double_flag} !== 4'b0000) bad++;
    end
    tests_run++;
    if (bad != 0) begin fail_cnt++; $display("FAIL reset_idle nonzero_cycles got %0d want 0", bad); end
  endtask

  task automatic test_bounce();
    int hi_cnt;
    int flag_cnt;
    hi_cnt = 0;
    flag_cnt = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge sys_clk);
      if (key_level !== 1'b0) hi_cnt++;
      if (short_flag || long_flag || double_flag) flag_cnt++;
      key_in = (n < 30 && (n % 5) < 3) ? 1'b0 : 1'b1;
    end
    tests_run++;
    if (hi_cnt != 0) begin fail_cnt++; $display("FAIL bounce_level high_cycles got %0d want 0", hi_cnt); end
    tests_run++;
    if (flag_cnt != 0) begin fail_cnt++; $display("FAIL bounce_flags got %0d want 0", flag_cnt); end
  endtask

  task automatic test_short_press();
    play(25, 0, 0, 80);
    tests_run++;
    if (rise1 != 6) begin fail_cnt++; $display("FAIL short_rise got %0d want 6", rise1); end
    tests_run++;
    if (fall1 != 31) begin fail_cnt++; $display("FAIL short_fall got %0d want 31", fall1); end
    tests_run++;
    if (short_idx != 53 || short_cnt != 1) begin
      fail_cnt++; $display("FAIL short_flag idx/cnt got %0d/%0d want 53/1", short_idx, short_cnt);
    end
    tests_run++;
    if (long_cnt != 0 || double_cnt != 0) begin
      fail_cnt++; $display("FAIL short_other long/double got %0d/%0d want 0/0", long_cnt, double_cnt);
    end
  endtask

  task automatic test_long_press();
    play(100, 0, 0, 160);
    tests_run++;
    if (rise1 != 6) begin fail_cnt++; $display("FAIL long_rise got %0d want 6", rise1); end
    tests_run++;
    if (long_idx != 48 || long_cnt != 1) begin
      fail_cnt++; $display("FAIL long_flag idx/cnt got %0d/%0d want 48/1", long_idx, long_cnt);
    end
    tests_run++;
    if (fall1 != 106) begin fail_cnt++; $display("FAIL long_fall got %0d want 106", fall1); end
    tests_run++;
    if (short_cnt != 0 || double_cnt != 0) begin
      fail_cnt++; $display("FAIL long_other short/double got %0d/%0d want 0/0", short_cnt, double_cnt);
    end
  endtask

  task automatic test_double_press();
    play(15, 10, 15, 80);
    tests_run++;
    if (rise1 != 6 || fall1 != 21 || rise2 != 31) begin
      fail_cnt++; $display("FAIL double_edges got %0d/%0d/%0d want 6/21/31", rise1, fall1, rise2);
    end
    tests_run++;
    if (double_idx != 32 || double_cnt != 1) begin
      fail_cnt++; $display("FAIL double_flag idx/cnt got %0d/%0d want 32/1", double_idx, double_cnt);
    end
    tests_run++;
    if (short_cnt != 0 || long_cnt != 0) begin
      fail_cnt++; $display("FAIL double_other short/long got %0d/%0d want 0/0", short_cnt, long_cnt);
    end
  endtask

  // Release lands exactly when tmr==CNT_LONG is evaluated: release wins.
  task automatic test_long_boundary();
    play(41, 0, 0, 100);
    tests_run++;
    if (fall1 != 47) begin fail_cnt++; $display("FAIL lboundary_fall got %0d want 47", fall1); end
    tests_run++;
    if (long_cnt != 0) begin fail_cnt++; $display("FAIL lboundary_long got %0d want 0", long_cnt); end
    tests_run++;
    if (short_idx != 69 || short_cnt != 1) begin
      fail_cnt++; $display("FAIL lboundary_short idx/cnt got %0d/%0d want 69/1", short_idx, short_cnt);
    end
  endtask

  // Second press lands exactly when tmr==CNT_DBL is evaluated: press wins.
  task automatic test_double_boundary();
    play(15, 21, 15, 100);
    tests_run++;
    if (rise2 != 42) begin fail_cnt++; $display("FAIL dboundary_rise2 got %0d want 42", rise2); end
    tests_run++;
    if (double_idx != 43 || double_cnt != 1 || short_cnt != 0) begin
      fail_cnt++;
      $display("FAIL dboundary_flags double idx/cnt %0d/%0d short %0d want 43/1/0", double_idx, double_cnt, short_cnt);
    end
  endtask

  task automatic test_back_to_back();
    play(25, 0, 0, 80);
    play(25, 0, 0, 80);
    tests_run++;
    if (short_idx != 53 || short_cnt != 1 || multi_cnt != 0) begin
      fail_cnt++; $display("FAIL b2b_short idx/cnt/multi got %0d/%0d/%0d want 53/1/0", short_idx, short_cnt, multi_cnt);
    end
  endtask

  task automatic test_reset_mid_press();
    int bad;
    for (int n = 0; n < 16; n++) begin
      @(negedge sys_clk);
      key_in = 1'b0;
    end
    @(negedge sys_clk);
    tests_run++;
    if (key_level !== 1'b1) begin fail_cnt++; $display("FAIL midrst_pressed got %b want 1", key_level); end
    sys_rst = 1'b1;
    #1;
    tests_run++;
    if ({key_level, short_flag, long_flag, double_flag} !== 4'b0000) begin
      fail_cnt++; $display("FAIL midrst_outputs got %b want 0000", {key_level, short_flag, long_flag, double_flag});
    end
    key_in = 1'b1;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    bad = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge sys_clk);
      if ({key_level, short_flag, long_flag, double_flag} !== 4'b0000) bad++;
    end
    tests_run++;
    if (bad != 0) begin fail_cnt++; $display("FAIL midrst_after nonzero_cycles got %0d want 0", bad); end
  endtask

  initial begin
    tests_run = 0;
    fail_cnt  = 0;
    sys_rst   = 1'b1;
    key_in    = 1'b1;
    test_reset();
    test_bounce();
    test_short_press();
    test_long_press();
    test_double_press();
    test_long_boundary();
    test_double_boundary();
    test_back_to_back();
    test_reset_mid_press();
    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
